serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB first through a single full-adder
// cell, and the result is held under a valid/ready output handshake.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one priming cycle, then one sum bit per cycle through u_fa
// DONE  | result held on sum/cout/ovf until out_ready

module fa_module (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_cout;

    fa_module u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Counter value 0 is a priming cycle; bit k is processed when r_cnt == k+1,
    // so the MSB lands on r_cnt == WIDTH, giving a WIDTH+1 cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt != '0) begin
                        r_a      <= r_a >> 1;
                        r_b      <= r_b >> 1;
                        r_carry  <= w_cout;
                        r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                        if (r_cnt == LAST) begin
                            // r_carry here is the carry into the MSB
                            r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
                            r_cout <= w_cout;
                            r_ovf  <= r_carry ^ w_cout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
